// File: rtl/burst_serializer_pkg.sv
// Shared types and geometry helpers for burst_serializer.
// Default geometry below matches the top-level parameter defaults.
package burst_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_PIXEL_BIT_WIDTH = 10;
  localparam int DEF_PIXELS_IN       = 10;
  localparam int DEF_PIXELS_OUT      = 1;
  localparam int DEF_IN_ROWS         = 20;
  localparam int DEF_IN_COLS         = 20;

  localparam int BEATS_PER_FRAME = DEF_IN_ROWS * DEF_IN_COLS / DEF_PIXELS_IN;
  localparam int GROUPS_PER_BEAT = DEF_PIXELS_IN / DEF_PIXELS_OUT;
  localparam int PIX_PER_FRAME   = DEF_IN_ROWS * DEF_IN_COLS;

  function automatic bit geometry_ok(input int in_rows, input int in_cols,
                                     input int pin, input int pout,
                                     input int crop_row0, input int crop_col0,
                                     input int out_rows, input int out_cols);
    return (in_cols % pin == 0) && (pin % pout == 0) &&
           (crop_col0 % pout == 0) && (out_cols % pout == 0) &&
           (crop_row0 + out_rows <= in_rows) && (crop_col0 + out_cols <= in_cols);
  endfunction

endpackage

// File: rtl/burst_serializer_if.sv
// AXI4-Stream style pixel bus used on both sides of burst_serializer.
interface burst_serializer_if #(
  parameter int DATA_WIDTH = 10,
  parameter int USER_WIDTH = 2
);
  import burst_serializer_pkg::*;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tlast;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/burst_slot_buffer.sv
// Two-slot ping-pong beat buffer; reads out one PIXELS_OUT-wide group at a time.
module burst_slot_buffer
  import burst_serializer_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int PIXELS_IN       = 10,
  parameter int PIXELS_OUT      = 1,
  parameter int USER_WIDTH      = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  wr_en,
  input  logic [PIXEL_BIT_WIDTH*PIXELS_IN-1:0]  wr_data,
  input  logic [USER_WIDTH-1:0]                 wr_user,
  input  logic                                  rd_en,
  output logic                                  full,
  output logic                                  empty,
  output logic [PIXEL_BIT_WIDTH*PIXELS_OUT-1:0] rd_data,
  output logic [USER_WIDTH-1:0]                 rd_user
);
  localparam int GROUPS = PIXELS_IN / PIXELS_OUT;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int BW     = PIXEL_BIT_WIDTH * PIXELS_IN;
  localparam int OW     = PIXEL_BIT_WIDTH * PIXELS_OUT;

  logic [BW-1:0]         data [2];
  logic [USER_WIDTH-1:0] user [2];
  logic [1:0]            valid;
  logic                  wr_ptr, rd_ptr, wr_sel, last_group;
  logic [GW-1:0]         grp;

  assign full       = &valid;
  assign empty      = ~|valid;
  assign last_group = (grp == GW'(GROUPS - 1));
  assign rd_data    = data[rd_ptr][int'(grp)*OW +: OW];
  assign rd_user    = user[rd_ptr];
  // A flushing write restarts the ping-pong at slot 0.
  assign wr_sel     = flush ? 1'b0 : wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      data   <= '{default: '0};
      user   <= '{default: '0};
      valid  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      grp    <= '0;
    end else begin
      if (flush) begin
        valid  <= '0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        grp    <= '0;
      end else if (rd_en) begin
        if (last_group) begin
          valid[rd_ptr] <= 1'b0;
          rd_ptr        <= ~rd_ptr;
          grp           <= '0;
        end else begin
          grp <= grp + 1'b1;
        end
      end
      if (wr_en) begin
        data[wr_sel]  <= wr_data;
        user[wr_sel]  <= wr_user;
        valid[wr_sel] <= 1'b1;
        wr_ptr        <= ~wr_sel;
      end
    end
  end
endmodule

// File: rtl/burst_serializer.sv
// Wide-beat to narrow-beat raster serializer with SOF sync and mid-frame SOF recovery.
// Optional crop window enabled by defining SEQZR_CROP_EN.
module burst_serializer
  import burst_serializer_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = DEF_PIXEL_BIT_WIDTH,
  parameter int PIXELS_IN       = DEF_PIXELS_IN,
  parameter int PIXELS_OUT      = DEF_PIXELS_OUT,
  parameter int USER_WIDTH      = 2,
  parameter int IN_ROWS         = DEF_IN_ROWS,
  parameter int IN_COLS         = DEF_IN_COLS,
  parameter int CROP_ROW0       = 0,
  parameter int CROP_COL0       = 0,
  parameter int OUT_ROWS        = 10,
  parameter int OUT_COLS        = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_axis_resetn,
  burst_serializer_if.slave          s_axis,
  burst_serializer_if.master         m_axis,
  output logic [$clog2(IN_ROWS)-1:0] cnt_row,
  output logic [$clog2(IN_COLS)-1:0] cnt_col,
  output logic                       frame_done,
  output logic                       err_sof
);
  localparam int BEATS = IN_ROWS * IN_COLS / PIXELS_IN;
  localparam int RW    = $clog2(IN_ROWS);
  localparam int CW    = $clog2(IN_COLS);
  localparam int BCW   = $clog2(BEATS + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - PIXELS_OUT);

  if (!geometry_ok(IN_ROWS, IN_COLS, PIXELS_IN, PIXELS_OUT,
                   CROP_ROW0, CROP_COL0, OUT_ROWS, OUT_COLS)) begin : g_bad_geometry
    $fatal(1, "burst_serializer: inconsistent frame/beat/crop geometry");
  end

  state_t                              state;
  logic [RW-1:0]                       pos_row, win_row;
  logic [CW-1:0]                       pos_col, win_col, tlast_col;
  logic [BCW-1:0]                      beats_in;
  logic                                rst_any, full, empty, in_win;
  logic                                s_hs, load, abort, consume, frame_end;
  logic [PIXEL_BIT_WIDTH*PIXELS_OUT-1:0] grp_data;
  logic [USER_WIDTH-1:0]               grp_user;

  assign rst_any = reset | ~s_axis_resetn;

  burst_slot_buffer #(
    .PIXEL_BIT_WIDTH(PIXEL_BIT_WIDTH),
    .PIXELS_IN      (PIXELS_IN),
    .PIXELS_OUT     (PIXELS_OUT),
    .USER_WIDTH     (USER_WIDTH)
  ) u_slots (
    .clk    (clk),
    .rst    (rst_any),
    .flush  (abort),
    .wr_en  (load),
    .wr_data(s_axis.tdata),
    .wr_user(s_axis.tuser),
    .rd_en  (consume),
    .full   (full),
    .empty  (empty),
    .rd_data(grp_data),
    .rd_user(grp_user)
  );

  always_comb begin
    s_axis.tready = 1'b0;
    if (!rst_any) begin
      case (state)
        IDLE:    s_axis.tready = 1'b1;
        RUN:     s_axis.tready = ~full & (beats_in < BCW'(BEATS));
        default: s_axis.tready = 1'b0;
      endcase
    end
  end

  assign s_hs      = s_axis.tvalid & s_axis.tready;
  assign abort     = s_hs & s_axis.tuser[0] & (state == RUN);
  assign load      = s_hs & (((state == IDLE) & s_axis.tuser[0]) | (state == RUN));
  // Groups outside the window retire without waiting for the sink.
  assign consume   = (state == RUN) & ~empty & (~in_win | m_axis.tready);
  assign frame_end = consume & (pos_row == ROW_LAST) & (pos_col == COL_LAST);

`ifdef SEQZR_CROP_EN
  assign in_win    = (int'(pos_row) >= CROP_ROW0) && (int'(pos_row) < CROP_ROW0 + OUT_ROWS) &&
                     (int'(pos_col) >= CROP_COL0) && (int'(pos_col) < CROP_COL0 + OUT_COLS);
  assign win_row   = RW'(int'(pos_row) - CROP_ROW0);
  assign win_col   = CW'(int'(pos_col) - CROP_COL0);
  assign tlast_col = CW'(OUT_COLS - PIXELS_OUT);
`else
  assign in_win    = 1'b1;
  assign win_row   = pos_row;
  assign win_col   = pos_col;
  assign tlast_col = COL_LAST;
`endif

  assign m_axis.tvalid = ~rst_any & (state == RUN) & ~empty & in_win;
  assign m_axis.tdata  = grp_data;
  assign m_axis.tlast  = m_axis.tvalid & (win_col == tlast_col);
  assign cnt_row       = in_win ? win_row : '0;
  assign cnt_col       = in_win ? win_col : '0;
  assign frame_done    = ~rst_any & (state == DONE);

  always_comb begin
    m_axis.tuser    = grp_user;
    m_axis.tuser[0] = m_axis.tvalid & (win_row == '0) & (win_col == '0);
  end

  always_ff @(posedge clk) begin
    if (rst_any) begin
      state    <= IDLE;
      pos_row  <= '0;
      pos_col  <= '0;
      beats_in <= '0;
      err_sof  <= 1'b0;
    end else begin
      err_sof <= abort;
      case (state)
        IDLE: begin
          if (load) begin
            state    <= RUN;
            beats_in <= BCW'(1);
          end
        end
        RUN: begin
          if (abort) begin
            beats_in <= BCW'(1);
            pos_row  <= '0;
            pos_col  <= '0;
          end else begin
            if (load) beats_in <= beats_in + 1'b1;
            if (frame_end) begin
              state    <= DONE;
              beats_in <= '0;
              pos_row  <= '0;
              pos_col  <= '0;
            end else if (consume) begin
              if (pos_col == COL_LAST) begin
                pos_col <= '0;
                pos_row <= pos_row + 1'b1;
              end else begin
                pos_col <= pos_col + CW'(PIXELS_OUT);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
